lbp_stream_engine: RTL and testbench

Parametrised streaming Local Binary Pattern engine, successor to the fixed 128x128 LBP block. Reads each grey pixel of an IMG_W x IMG_H image exactly once, in raster order, through the same request/ready memory port. Keeps two line buffers and a 3x3 window, and writes one 8-bit LBP code per interior pixel to the result memory. Image size is set by parameters; stalls on `gray_ready`; optional uniform-pattern mapping.

---
 rtl/lbp_pkg.sv | 55 +++++
 rtl/lbp_line_buf.sv | 31 +++
 rtl/lbp_stream_engine.sv | 130 +++++++++++++
 tb/tb_lbp_stream_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared types, neighbour bit positions and the uniform-pattern mapping
// for the streaming LBP engine.
package lbp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } lbp_state_t;

    localparam int NB_TL = 0;
    localparam int NB_T  = 1;
    localparam int NB_TR = 2;
    localparam int NB_L  = 3;
    localparam int NB_R  = 4;
    localparam int NB_BL = 5;
    localparam int NB_B  = 6;
    localparam int NB_BR = 7;

    localparam int UNIFORM_OTHER = 58;

    function automatic int lbp_transitions(input logic [7:0] code);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (code[3'(k)] != code[3'(k + 1)]) n++;
        end
        return n;
    endfunction

    // Elaboration-time table: uniform codes numbered in ascending raw order.
    function automatic logic [2047:0] lbp_build_uniform_lut();
        logic [2047:0] lut;
        logic [7:0]    idx;
        lut = '0;
        idx = '0;
        for (int i = 0; i < 256; i++) begin
            if (lbp_transitions(8'(i)) <= 2) begin
                lut[i*8 +: 8] = idx;
                idx           = idx + 8'd1;
            end else begin
                lut[i*8 +: 8] = 8'(UNIFORM_OTHER);
            end
        end
        return lut;
    endfunction

    localparam logic [2047:0] UNIFORM_LUT = lbp_build_uniform_lut();

    function automatic logic [7:0] lbp_uniform_map(input logic [7:0] code);
        return UNIFORM_LUT[{code, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lbp_line_buf.sv
// Two IMG_W-deep line buffers holding rows r-2 and r-1, addressed by the
// current column; read-before-write on every accepted pixel.
module lbp_line_buf #(
    parameter int IMG_W = 128,
    parameter int PIX_W = 8,
    parameter int CW    = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [CW-1:0]    col,
    input  logic [PIX_W-1:0] pix_in,
    output logic [PIX_W-1:0] above2,
    output logic [PIX_W-1:0] above1
);

    logic [PIX_W-1:0] line0 [IMG_W];
    logic [PIX_W-1:0] line1 [IMG_W];

    assign above2 = line0[col];
    assign above1 = line1[col];

    // NOTE: storage arrays carry no reset; the window qualifier masks any
    // entry that has not yet been written this frame.
    always_ff @(posedge clk) begin
        if (we) begin
            line0[col] <= line1[col];
            line1[col] <= pix_in;
        end
    end

endmodule

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine: raster reads, one code per interior pixel.
// Define LBP_UNIFORM_EN to emit uniform-pattern indices instead of raw codes.
module lbp_stream_engine
    import lbp_pkg::*;
#(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int PIX_W = 8,
    parameter int AW    = $clog2(IMG_W*IMG_H)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             gray_ready,
    output logic             gray_req,
    output logic [AW-1:0]    gray_addr,
    input  logic [PIX_W-1:0] gray_data,
    output logic             lbp_valid,
    output logic [AW-1:0]    lbp_addr,
    output logic [7:0]       lbp_data,
    output logic             finish
);

    localparam int N  = IMG_W * IMG_H;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    lbp_state_t       state, state_nxt;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             last_pix;
    logic [PIX_W-1:0] above2, above1;
    logic [PIX_W-1:0] win [3][3];
    logic             win_valid;
    logic [AW-1:0]    win_addr;
    logic [7:0]       code, code_out;

    lbp_line_buf #(.IMG_W(IMG_W), .PIX_W(PIX_W), .CW(CW)) u_line_buf (
        .clk    (clk),
        .we     (gray_req),
        .col    (col),
        .pix_in (gray_data),
        .above2 (above2),
        .above1 (above1)
    );

    assign last_pix = (gray_addr == AW'(N - 1));
    assign finish   = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and a latch cannot be inferred.
    always_comb begin
        state_nxt = state;
        gray_req  = 1'b0;
        case (state)
            IDLE:  if (gray_ready) state_nxt = READ;
            READ: begin
                gray_req = gray_ready;
                if (gray_ready && last_pix) state_nxt = DRAIN;
            end
            DRAIN: if (lbp_valid && !win_valid) state_nxt = DONE;
            DONE:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours (the window shift relies on it).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gray_addr <= '0;
            row       <= '0;
            col       <= '0;
            win       <= '{default: '0};
            win_valid <= 1'b0;
            win_addr  <= '0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
        end else begin
            win_valid <= 1'b0;
            if (gray_req) begin
                gray_addr <= gray_addr + 1'b1;
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                for (int i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= above2;
                win[1][2] <= above1;
                win[2][2] <= gray_data;
                // Columns left over from the previous row are never qualified.
                win_valid <= (row >= RW'(2)) && (col >= CW'(2));
                win_addr  <= gray_addr - AW'(IMG_W + 1);
            end
            lbp_valid <= win_valid;
            if (win_valid) begin
                lbp_addr <= win_addr;
                lbp_data <= code_out;
            end
        end
    end

    always_comb begin
        code        = '0;
        code[NB_TL] = win[0][0] >= win[1][1];
        code[NB_T]  = win[0][1] >= win[1][1];
        code[NB_TR] = win[0][2] >= win[1][1];
        code[NB_L]  = win[1][0] >= win[1][1];
        code[NB_R]  = win[1][2] >= win[1][1];
        code[NB_BL] = win[2][0] >= win[1][1];
        code[NB_B]  = win[2][1] >= win[1][1];
        code[NB_BR] = win[2][2] >= win[1][1];
`ifdef LBP_UNIFORM_EN
        code_out    = lbp_uniform_map(code);
`else
        code_out    = code;
`endif
    end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Self-checking bench for lbp_stream_engine on a 7x5 image: random images and
// ready patterns checked cycle by cycle against a plain arithmetic LBP model.
module tb_lbp_stream_engine;

    localparam int IMG_W  = 7;
    localparam int IMG_H  = 5;
    localparam int PIX_W  = 8;
    localparam int N      = IMG_W * IMG_H;
    localparam int AW     = $clog2(N);
    localparam int BUDGET = 600;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             gray_ready = 1'b0;
    logic             gray_req;
    logic [AW-1:0]    gray_addr;
    logic [PIX_W-1:0] gray_data;
    logic             lbp_valid;
    logic [AW-1:0]    lbp_addr;
    logic [7:0]       lbp_data;
    logic             finish;

    logic [PIX_W-1:0] img [2**AW];
    int n_vec = 0;
    int n_err = 0;

    assign gray_data = img[gray_addr];

    always #5 clk = ~clk;

    lbp_stream_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .AW(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish)
    );

    function automatic int ref_transitions(input logic [7:0] c);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (c[k] != c[(k + 1) % 8]) n++;
        end
        return n;
    endfunction

    // Reference LBP for the pixel at raster address a (must be interior).
    function automatic logic [7:0] ref_code(input int a);
        logic [PIX_W-1:0] ctr;
        logic [PIX_W-1:0] nb [8];
        logic [7:0]       c;
        int               idx;
        ctr   = img[a];
        nb[0] = img[a - IMG_W - 1];
        nb[1] = img[a - IMG_W];
        nb[2] = img[a - IMG_W + 1];
        nb[3] = img[a - 1];
        nb[4] = img[a + 1];
        nb[5] = img[a + IMG_W - 1];
        nb[6] = img[a + IMG_W];
        nb[7] = img[a + IMG_W + 1];
        for (int k = 0; k < 8; k++) c[k] = (nb[k] >= ctr);
`ifdef LBP_UNIFORM_EN
        if (ref_transitions(c) > 2) return 8'd58;
        idx = 0;
        for (int u = 0; u < int'(c); u++) begin
            if (ref_transitions(8'(u)) <= 2) idx++;
        end
        return 8'(idx);
`else
        idx = 0;
        return c + 8'(idx);
`endif
    endfunction

    task automatic fill_image(input int mode);
        for (int i = 0; i < 2**AW; i++) img[i] = '0;
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       img[i] = PIX_W'($urandom);
                1:       img[i] = 8'h40;
                2:       img[i] = PIX_W'(i);
                default: img[i] = PIX_W'($urandom_range(0, 3));
            endcase
        end
    endtask

    // Called at a negedge: pulses reset for one cycle and checks cleared outputs.
    task automatic apply_reset(input string name);
        reset_n    = 1'b0;
        gray_ready = 1'b0;
        #1;
        n_vec += 6;
        if (gray_req !== 1'b0)  begin n_err++; $display("FAIL %s rst gray_req got %b want 0", name, gray_req); end
        if (gray_addr !== '0)   begin n_err++; $display("FAIL %s rst gray_addr got %0d want 0", name, gray_addr); end
        if (lbp_valid !== 1'b0) begin n_err++; $display("FAIL %s rst lbp_valid got %b want 0", name, lbp_valid); end
        if (lbp_addr !== '0)    begin n_err++; $display("FAIL %s rst lbp_addr got %0d want 0", name, lbp_addr); end
        if (lbp_data !== '0)    begin n_err++; $display("FAIL %s rst lbp_data got %0d want 0", name, lbp_data); end
        if (finish !== 1'b0)    begin n_err++; $display("FAIL %s rst finish got %b want 0", name, finish); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ready_mode: 0 always ready, 1 toggling, 2 random. abort_at >= 0 resets mid-frame.
    task automatic run_frame(input int ready_mode, input int abort_at, input string name);
        int            exp_t[$];
        int            exp_a[$];
        logic [AW-1:0] exp_addr;
        int            t_last;
        bit            exp_v, exp_f;
        int            a;
        exp_addr = '0;
        t_last   = -1;
        for (int t = 0; t < BUDGET; t++) begin
            @(negedge clk);
            n_vec++;
            if (gray_addr !== exp_addr) begin
                n_err++; $display("FAIL %s gray_addr t=%0d got %0d want %0d", name, t, gray_addr, exp_addr);
            end
            exp_v = (exp_t.size() > 0) && (exp_t[0] == t);
            n_vec++;
            if (lbp_valid !== exp_v) begin
                n_err++; $display("FAIL %s lbp_valid t=%0d got %b want %b", name, t, lbp_valid, exp_v);
            end
            if (exp_v) begin
                n_vec += 2;
                if (lbp_addr !== AW'(exp_a[0])) begin
                    n_err++; $display("FAIL %s lbp_addr t=%0d got %0d want %0d", name, t, lbp_addr, exp_a[0]);
                end
                if (lbp_data !== ref_code(exp_a[0])) begin
                    n_err++; $display("FAIL %s lbp_data addr=%0d got %h want %h", name, exp_a[0], lbp_data, ref_code(exp_a[0]));
                end
                void'(exp_t.pop_front());
                void'(exp_a.pop_front());
            end
            exp_f = (t_last >= 0) && (t > t_last);
            n_vec++;
            if (finish !== exp_f) begin
                n_err++; $display("FAIL %s finish t=%0d got %b want %b", name, t, finish, exp_f);
            end
            if (t == abort_at) begin
                apply_reset(name);
                return;
            end
            if (t_last >= 0 && t == t_last + 3) return;
            case (ready_mode)
                0:       gray_ready = 1'b1;
                1:       gray_ready = (t % 2 == 0);
                default: gray_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (!gray_ready || t_last >= 0) begin
                n_vec++;
                if (gray_req !== 1'b0) begin
                    n_err++; $display("FAIL %s gray_req t=%0d got %b want 0", name, t, gray_req);
                end
            end
            if (gray_req === 1'b1) begin
                a = int'(gray_addr);
                if ((a / IMG_W) >= 2 && (a % IMG_W) >= 2) begin
                    exp_t.push_back(t + 2);
                    exp_a.push_back(a - IMG_W - 1);
                end
                if (a == N - 1) t_last = t + 2;
                exp_addr = exp_addr + 1'b1;
            end
        end
        n_err++;
        $display("FAIL %s timeout got no finish within %0d cycles want finish", name, BUDGET);
    endtask

    task automatic start_frame(input int fill, input string name);
        fill_image(fill);
        @(negedge clk);
        apply_reset(name);
    endtask

    task automatic test_reset();
        @(negedge clk);
        apply_reset("reset");
    endtask

    task automatic test_constant();
        start_frame(1, "constant");
        run_frame(0, -1, "constant");
    endtask

    task automatic test_ramp();
        start_frame(2, "ramp");
        run_frame(0, -1, "ramp");
    endtask

    task automatic test_random();
        start_frame(0, "random");
        run_frame(0, -1, "random");
    endtask

    task automatic test_stall_toggle();
        start_frame(0, "toggle");
        run_frame(1, -1, "toggle");
    endtask

    task automatic test_random_stall();
        for (int i = 0; i < 3; i++) begin
            start_frame(3, "rand_stall");
            run_frame(2, -1, "rand_stall");
        end
    endtask

    task automatic test_reset_mid_frame();
        start_frame(0, "mid_reset");
        run_frame(0, 3 * IMG_W + 3, "mid_reset");
        run_frame(0, -1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_random();
        test_stall_toggle();
        test_random_stall();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
